uart_bus_master: RTL

//  Bus initiator that drives the UART command port (id/din/write) on behalf of streaming logic.

---
 rtl/uart_bus_master_if.sv | 39 +++
 rtl/uart_bus_master.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_master_if.sv
// ============================================================================
// Module      : uart_bus_master_if
// Description : Stream, baud-request and UART command signals of uart_bus_master.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_bus_master_if;
    logic [15:0] baud_div;
    logic        baud_load;
    logic [7:0]  tx_data;
    logic        tx_last;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  uart_dout;
    logic [11:0] uart_rxcount;
    logic [11:0] uart_txcount;
    logic [15:0] id;
    logic [15:0] dout;
    logic        write;
    logic        busy;

    modport master (
        input  baud_div, baud_load, tx_data, tx_last, tx_valid, rx_ready,
               uart_dout, uart_rxcount, uart_txcount,
        output tx_ready, rx_data, rx_valid, id, dout, write, busy
    );

    modport slave (
        output baud_div, baud_load, tx_data, tx_last, tx_valid, rx_ready,
               uart_dout, uart_rxcount, uart_txcount,
        input  tx_ready, rx_data, rx_valid, id, dout, write, busy
    );
endinterface

`default_nettype wire

// File: rtl/uart_bus_master.sv
// ============================================================================
// Module      : uart_bus_master
// Description : Drives the UART command port from TX/RX byte streams and baud
//               requests. Define UART_INIT_PURGE_EN to purge both buffers
//               after reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_bus_master #(
    parameter logic [15:0] ID_BASE        = 16'h0200,
    parameter logic [11:0] TX_HIGH_WATER  = 12'd1000,
    parameter int          RX_WAIT_CYCLES = 3
) (
    input  wire logic       clk,
    input  wire logic       reset_n,
    uart_bus_master_if.master bus
);

    localparam logic [7:0] C_WAIT_LAST = 8'(RX_WAIT_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        BAUD     = 4'd1,
        TXSTORE  = 4'd2,
        TXFLUSH  = 4'd3,
        RXCHK    = 4'd4,
        RXPOP    = 4'd5,
        RXWAIT   = 4'd6
`ifdef UART_INIT_PURGE_EN
        ,
        INIT_TXP = 4'd7,
        INIT_RXP = 4'd8
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] id_q, id_d;
    logic [15:0] dout_q, dout_d;
    logic        write_q, write_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        baud_pend_q, baud_pend_d;
    logic [15:0] baud_div_q, baud_div_d;
    logic        tx_last_q, tx_last_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        init_pend_q, init_pend_d;

    logic w_baud_req;
    logic w_rx_elig;
    logic w_tx_ready;
    logic w_tx_fire;

    // A load arriving this cycle already counts as pending, so it wins over
    // an RX pop or TX accept offered at the same time.
    assign w_baud_req = baud_pend_q || bus.baud_load;
    assign w_rx_elig  = (bus.uart_rxcount != 12'd0) && !rx_valid_q;
    assign w_tx_ready = reset_n && (state_q == IDLE) && !w_baud_req && !w_rx_elig
                        && !init_pend_q && (bus.uart_txcount < TX_HIGH_WATER);
    assign w_tx_fire  = bus.tx_valid && w_tx_ready;

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        dout_d      = dout_q;
        write_d     = 1'b0;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q && !bus.rx_ready;
        baud_pend_d = w_baud_req;
        baud_div_d  = bus.baud_load ? bus.baud_div : baud_div_q;
        tx_last_d   = tx_last_q;
        wait_cnt_d  = wait_cnt_q;
        init_pend_d = init_pend_q;
        // Outputs are set on entry so write/id/dout line up with the write state.
        case (state_q)
            IDLE: begin
`ifdef UART_INIT_PURGE_EN
                if (init_pend_q) begin
                    state_d = INIT_TXP;
                    write_d = 1'b1;
                    id_d    = ID_BASE + 16'd3;
                    dout_d  = 16'h0000;
                end else
`endif
                if (w_baud_req) begin
                    state_d     = BAUD;
                    write_d     = 1'b1;
                    id_d        = ID_BASE;
                    dout_d      = baud_div_d;
                    baud_pend_d = 1'b0;
                end else if (w_rx_elig) begin
                    state_d = RXCHK;
                end else if (w_tx_fire) begin
                    state_d   = TXSTORE;
                    write_d   = 1'b1;
                    id_d      = ID_BASE + 16'd1;
                    dout_d    = {8'h00, bus.tx_data};
                    tx_last_d = bus.tx_last;
                end
            end
            BAUD:    state_d = IDLE;
            TXSTORE: begin
                if (tx_last_q) begin
                    state_d = TXFLUSH;
                    write_d = 1'b1;
                    id_d    = ID_BASE + 16'd2;
                    dout_d  = 16'h0000;
                end else begin
                    state_d = IDLE;
                end
            end
            TXFLUSH: state_d = IDLE;
            RXCHK: begin
                state_d    = RXPOP;
                write_d    = 1'b1;
                id_d       = ID_BASE + 16'd4;
                dout_d     = 16'h0000;
                rx_data_d  = bus.uart_dout;
                rx_valid_d = 1'b1;
            end
            RXPOP: begin
                state_d    = RXWAIT;
                wait_cnt_d = 8'd0;
            end
            RXWAIT: begin
                if (wait_cnt_q == C_WAIT_LAST) begin
                    state_d = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
`ifdef UART_INIT_PURGE_EN
            INIT_TXP: begin
                state_d     = INIT_RXP;
                write_d     = 1'b1;
                id_d        = ID_BASE + 16'd5;
                dout_d      = 16'h0000;
                init_pend_d = 1'b0;
            end
            INIT_RXP: state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            id_q        <= 16'h0000;
            dout_q      <= 16'h0000;
            write_q     <= 1'b0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            baud_pend_q <= 1'b0;
            baud_div_q  <= 16'h0000;
            tx_last_q   <= 1'b0;
            wait_cnt_q  <= 8'd0;
`ifdef UART_INIT_PURGE_EN
            init_pend_q <= 1'b1;
`else
            init_pend_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            dout_q      <= dout_d;
            write_q     <= write_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            baud_pend_q <= baud_pend_d;
            baud_div_q  <= baud_div_d;
            tx_last_q   <= tx_last_d;
            wait_cnt_q  <= wait_cnt_d;
            init_pend_q <= init_pend_d;
        end
    end

    assign bus.tx_ready = w_tx_ready;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.id       = id_q;
    assign bus.dout     = dout_q;
    assign bus.write    = write_q;
    assign bus.busy     = (state_q != IDLE);

endmodule

`default_nettype wire
